// File: rtl/fp_mul_rne.sv
// fp_mul_rne: parametrised floating-point multiplier with a valid/ready handshake.
// Round-to-nearest-even, denormals treated as zero, overflow saturates to infinity.
// One operation in flight; fixed three-cycle latency from accept to out_valid.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   MUL   | classify operands, form sign, biased exponent and raw product
//   NORM  | normalise product, extract mantissa plus guard/round/sticky
//   RND   | round, detect overflow/underflow, pack result and flags
//   DONE  | hold result until the consumer takes it
module fp_mul_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   z,
  output logic                   flg_invalid,
  output logic                   flg_overflow,
  output logic                   flg_underflow,
  output logic                   flg_inexact
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W+1:0] BIAS = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W+1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_RND, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [W-1:0]       r_a, r_b;
  logic               r_sign;
  logic [EXP_W+1:0]   r_exp;
  logic [PW-1:0]      r_prod;
  logic [MAN_W:0]     r_man;
  logic               r_g, r_r, r_s;
  logic               r_spec, r_spec_inv;
  logic [W-1:0]       r_spec_z;
  logic               r_out_valid;
  logic [W-1:0]       r_z;
  logic               r_inv, r_ovf, r_unf, r_inx;

  // Operand fields and classes (exp==0 counts as zero whatever the fraction).
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_sign;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign w_ea     = r_a[W-2:MAN_W];
  assign w_eb     = r_b[W-2:MAN_W];
  assign w_fa     = r_a[MAN_W-1:0];
  assign w_fb     = r_b[MAN_W-1:0];
  assign w_sign   = r_a[W-1] ^ r_b[W-1];
  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_b_nan  = (&w_eb) & (|w_fb);
  assign w_a_inf  = (&w_ea) & ~(|w_fa);
  assign w_b_inf  = (&w_eb) & ~(|w_fb);
  assign w_a_zero = ~(|w_ea);
  assign w_b_zero = ~(|w_eb);

  logic [EXP_W+1:0] w_exp_mul;
  logic [PW-1:0]    w_prod;

  assign w_exp_mul = {2'b00, w_ea} + {2'b00, w_eb} - BIAS;
  assign w_prod    = {{(MAN_W+1){1'b0}}, 1'b1, w_fa} * {{(MAN_W+1){1'b0}}, 1'b1, w_fb};

  logic           w_spec, w_spec_inv;
  logic [W-1:0]   w_spec_z;

  // Special-operand resolution in priority order: NaN, inf*0, inf, zero.
  always_comb begin
    w_spec     = 1'b0;
    w_spec_inv = 1'b0;
    w_spec_z   = '0;
    if (w_a_nan | w_b_nan) begin
      w_spec     = 1'b1;
      w_spec_z   = QNAN;
      w_spec_inv = (w_a_nan & ~w_fa[MAN_W-1]) | (w_b_nan & ~w_fb[MAN_W-1]);
    end else if ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
      w_spec     = 1'b1;
      w_spec_z   = QNAN;
      w_spec_inv = 1'b1;
    end else if (w_a_inf | w_b_inf) begin
      w_spec   = 1'b1;
      w_spec_z = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_a_zero | w_b_zero) begin
      w_spec   = 1'b1;
      w_spec_z = {w_sign, {(EXP_W+MAN_W){1'b0}}};
    end
  end

  // Normalisation: shift left by one when the product MSB is clear.
  logic [PW-1:0]    w_pn;
  logic [EXP_W+1:0] w_exp_norm;

  assign w_pn       = r_prod[PW-1] ? r_prod : {r_prod[PW-2:0], 1'b0};
  assign w_exp_norm = r_exp + {{(EXP_W+1){1'b0}}, r_prod[PW-1]};

  // Rounding: mantissa carry-out renormalises and bumps the exponent.
  logic             w_inc;
  logic [MAN_W+1:0] w_sum;
  logic [MAN_W-1:0] w_frac;
  logic [EXP_W+1:0] w_exp_rnd;
  logic             w_ovf, w_unf;

  assign w_inc     = r_g & (r_r | r_s | r_man[0]);
  assign w_sum     = {1'b0, r_man} + {{(MAN_W+1){1'b0}}, w_inc};
  assign w_frac    = w_sum[MAN_W+1] ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
  assign w_exp_rnd = r_exp + {{(EXP_W+1){1'b0}}, w_sum[MAN_W+1]};
  assign w_ovf     = ~w_exp_rnd[EXP_W+1] & (w_exp_rnd >= EMAX);
  assign w_unf     = w_exp_rnd[EXP_W+1] | (w_exp_rnd == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_MUL;
      S_MUL:   w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_RND;
      S_RND:   w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake output decode.
  always_comb begin
    in_ready = (r_state == S_IDLE) & ~rst;
  end

  // Datapath pipeline registers; no reset needed, they are qualified by state.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (in_valid & in_ready) begin
          r_a <= a;
          r_b <= b;
        end
      end
      S_MUL: begin
        r_sign     <= w_sign;
        r_exp      <= w_exp_mul;
        r_prod     <= w_prod;
        r_spec     <= w_spec;
        r_spec_z   <= w_spec_z;
        r_spec_inv <= w_spec_inv;
      end
      S_NORM: begin
        r_exp <= w_exp_norm;
        r_man <= w_pn[PW-1:MAN_W+1];
        r_g   <= w_pn[MAN_W];
        r_r   <= w_pn[MAN_W-1];
        r_s   <= |w_pn[MAN_W-2:0];
      end
      default: ;
    endcase
  end

  // Result and flag registers, stable while DONE waits for out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_z         <= '0;
      r_inv       <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_inx       <= 1'b0;
    end else if (r_state == S_RND) begin
      r_out_valid <= 1'b1;
      r_inv       <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_inx       <= 1'b0;
      if (r_spec) begin
        r_z   <= r_spec_z;
        r_inv <= r_spec_inv;
      end else if (w_ovf) begin
        r_z   <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        r_ovf <= 1'b1;
        r_inx <= 1'b1;
      end else if (w_unf) begin
        r_z   <= {r_sign, {(EXP_W+MAN_W){1'b0}}};
        r_unf <= 1'b1;
        r_inx <= 1'b1;
      end else begin
        r_z   <= {r_sign, w_exp_rnd[EXP_W-1:0], w_frac};
        r_inx <= r_g | r_r | r_s;
      end
    end else if ((r_state == S_DONE) & out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign z             = r_z;
  assign flg_invalid   = r_inv;
  assign flg_overflow  = r_ovf;
  assign flg_underflow = r_unf;
  assign flg_inexact   = r_inx;

endmodule

// File: tb/tb_fp_mul_rne.sv
// tb_fp_mul_rne: directed and randomised checks of fp_mul_rne (single precision)
// against an integer-arithmetic model of IEEE multiply with RNE and DAZ.
module tb_fp_mul_rne;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, z;
  logic        flg_invalid, flg_overflow, flg_underflow, flg_inexact;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mul_rne #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .z(z),
    .flg_invalid(flg_invalid), .flg_overflow(flg_overflow),
    .flg_underflow(flg_underflow), .flg_inexact(flg_inexact)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Returns {z, invalid, overflow, underflow, inexact}.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    logic        sx, sy, sgn;
    int          ex, ey, e, sh;
    logic [22:0] fx, fy;
    logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, inx;
    logic [63:0] p, q, rem, half;
    sx = x[31]; ex = int'(x[30:23]); fx = x[22:0];
    sy = y[31]; ey = int'(y[30:23]); fy = y[22:0];
    sgn    = sx ^ sy;
    x_nan  = (ex == 255) && (fx != 0);
    y_nan  = (ey == 255) && (fy != 0);
    x_inf  = (ex == 255) && (fx == 0);
    y_inf  = (ey == 255) && (fy == 0);
    x_zero = (ex == 0);
    y_zero = (ey == 0);
    if (x_nan || y_nan)
      return {32'h7FC00000, ((x_nan && !fx[22]) || (y_nan && !fy[22])), 3'b000};
    if ((x_inf && y_zero) || (x_zero && y_inf))
      return {32'h7FC00000, 4'b1000};
    if (x_inf || y_inf)
      return {sgn, 8'hFF, 23'd0, 4'b0000};
    if (x_zero || y_zero)
      return {sgn, 31'd0, 4'b0000};
    p = {40'd0, 1'b1, fx} * {40'd0, 1'b1, fy};
    e = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 0);
    if ((rem > half) || ((rem == half) && q[0])) q = q + 64'd1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sgn, 8'hFF, 23'd0, 4'b0101};
    if (e <= 0)   return {sgn, 31'd0, 4'b0011};
    return {sgn, e[7:0], q[22:0], 3'b000, inx};
  endfunction

  // Caller is positioned at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] exp_z, input logic [3:0] exp_f,
                        input int hold, input bit poke);
    int          lat;
    logic [31:0] z0;
    logic [3:0]  f0;
    check_eq({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    a = ia; b = ib; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, ".latency"}, 64'(lat - 1), 64'd3);
    check_eq({tag, ".z"}, {32'd0, z}, {32'd0, exp_z});
    check_eq({tag, ".flags"},
             {60'd0, flg_invalid, flg_overflow, flg_underflow, flg_inexact}, {60'd0, exp_f});
    z0 = z;
    f0 = {flg_invalid, flg_overflow, flg_underflow, flg_inexact};
    for (int i = 0; i < hold; i++) begin
      in_valid = poke;
      a = $urandom; b = $urandom;
      @(negedge clk);
      check_eq({tag, ".hold"},
               {26'd0, out_valid, in_ready, z, flg_invalid, flg_overflow, flg_underflow, flg_inexact},
               {26'd0, 1'b1, 1'b0, z0, f0});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, ".release"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic [35:0] m;
    logic [31:0] ra, rb;
    int          mode, hold;
    bit          seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_eq("reset.out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("reset.z", {32'd0, z}, 64'd0);
    check_eq("reset.flags", {60'd0, flg_invalid, flg_overflow, flg_underflow, flg_inexact}, 64'd0);
    check_eq("reset.in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("basic",    32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 0, 1'b0);
    run_op("tie_up",   32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 0, 1'b0);
    run_op("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 0, 1'b0);
    run_op("inf_zero", 32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000, 0, 1'b0);
    run_op("snan",     32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 0, 1'b0);
    run_op("qnan",     32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 0, 1'b0);
    run_op("inf_fin",  32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, 0, 1'b0);
    run_op("underflow",32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 0, 1'b0);
    run_op("daz",      32'h80000001, 32'h3F800000, 32'h80000000, 4'b0000, 0, 1'b0);
    run_op("backpress",32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 5, 1'b1);

    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("poke_ignored", {63'd0, seen}, 64'd0);

    // Reset during NORM discards the operation.
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("rst.in_ready_low", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst.out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check_eq("rst.in_ready_high", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("rst.no_result", {63'd0, seen}, 64'd0);
    run_op("after_rst", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 3);
      ra = $urandom;
      rb = $urandom;
      if (mode == 1 || mode == 2) begin
        ra[30:23] = 8'($urandom_range(100, 154));
        rb[30:23] = 8'($urandom_range(100, 154));
      end else if (mode == 3) begin
        case ($urandom_range(0, 3))
          0: ra[30:23] = 8'hFF;
          1: ra[30:23] = 8'h00;
          2: begin ra[30:23] = 8'hFF; ra[22:0] = '0; end
          default: rb[30:23] = 8'h00;
        endcase
      end
      m    = model(ra, rb);
      hold = $urandom_range(0, 2);
      run_op("rand", ra, rb, m[35:4], m[3:0], hold, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
